// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: redirect/halt control, predictor lookup and I-cache request.
interface fetch_pc_gen_if #(
  parameter int unsigned VADDR_WIDTH = 39,
  parameter int unsigned EPOCH_WIDTH = 3
);
  logic                   redirect_valid;
  logic [VADDR_WIDTH-1:0] redirect_pc;
  logic                   fetch_halt;
  logic [VADDR_WIDTH-1:0] bp_pc;
  logic                   bp_predict_valid;
  logic                   bp_pred_valid;
  logic                   bp_pred_taken;
  logic [VADDR_WIDTH-1:0] bp_pred_target;
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic [VADDR_WIDTH-1:0] fetch_pc;
  logic                   fetch_pred_taken;
  logic [VADDR_WIDTH-1:0] fetch_pred_target;
  logic [EPOCH_WIDTH-1:0] fetch_epoch;
  logic                   flush;

  // PC generator side
  modport master (
    input  redirect_valid, redirect_pc, fetch_halt,
    input  bp_pred_valid, bp_pred_taken, bp_pred_target, fetch_ready,
    output bp_pc, bp_predict_valid, fetch_valid, fetch_pc,
    output fetch_pred_taken, fetch_pred_target, fetch_epoch, flush
  );

  // Environment side (backend, predictor, I-cache)
  modport slave (
    output redirect_valid, redirect_pc, fetch_halt,
    output bp_pred_valid, bp_pred_taken, bp_pred_target, fetch_ready,
    input  bp_pc, bp_predict_valid, fetch_valid, fetch_pc,
    input  fetch_pred_taken, fetch_pred_target, fetch_epoch, flush
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC generation: redirect > predicted-taken > sequential, epoch-tagged fetch requests.
module fetch_pc_gen #(
  parameter int unsigned            VADDR_WIDTH  = 39,
  parameter logic [VADDR_WIDTH-1:0] RESET_VECTOR = 39'h0080000000,
  parameter int unsigned            EPOCH_WIDTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  fetch_pc_gen_if.master    bus
);

  localparam logic [VADDR_WIDTH-1:0] ALIGN_MASK = ~VADDR_WIDTH'(3);
  localparam logic [VADDR_WIDTH-1:0] PC_STEP    = VADDR_WIDTH'(4);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [VADDR_WIDTH-1:0] pc_q, pc_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;

  logic fetch_valid_c;
  logic fire_c;
  logic taken_pred_c;

  // State, PC and epoch registers; reset takes precedence over any redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  // Next-state selection and request/handshake outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    fetch_valid_c = 1'b0;
    fire_c        = 1'b0;
    taken_pred_c  = bus.bp_pred_valid && bus.bp_pred_taken;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     fetch_valid_c = !rst && !bus.redirect_valid && !bus.fetch_halt;
      default: state_d = BOOT;
    endcase

    fire_c = fetch_valid_c && bus.fetch_ready;

    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & ALIGN_MASK;
      epoch_d = epoch_q + EPOCH_WIDTH'(1);
      state_d = RUN;
    end else if (fire_c && taken_pred_c) begin
      pc_d = bus.bp_pred_target & ALIGN_MASK;
    end else if (fire_c) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Predictor sees only committed lookups so its RAS is not disturbed by stalls
  always_comb begin
    bus.bp_pc             = pc_q;
    bus.fetch_pc          = pc_q;
    bus.fetch_valid       = fetch_valid_c;
    bus.bp_predict_valid  = fire_c;
    bus.fetch_pred_taken  = taken_pred_c;
    bus.fetch_pred_target = taken_pred_c ? bus.bp_pred_target : '0;
    bus.fetch_epoch       = epoch_q;
    bus.flush             = bus.redirect_valid && !rst;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Next-PC generation stage that sits directly upstream of branch_predictor and feeds the I-cache fetch request port.
- Holds the architectural fetch PC and presents it to the predictor every cycle.
- Picks the next PC from, in priority order: backend redirect, predicted-taken target, sequential PC+4.
- Tags every fetch with an epoch so the downstream fetch queue can drop wrong-path entries.

Parameters:
VADDR_WIDTH, 39, virtual address width
RESET_VECTOR, 39'h0080000000, first fetch PC after reset
EPOCH_WIDTH, 3, width of the redirect epoch counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect_valid  in  1  backend redirect (mispredict/exception/fence.i)
redirect_pc  in  VADDR_WIDTH  redirect target; bits [1:0] ignored
fetch_halt  in  1  hold fetch (WFI/debug); no state change except redirect
bp_pc  out  VADDR_WIDTH  PC driven to predictor
bp_predict_valid  out  1  predictor lookup commit (drives predictor RAS push/pop)
bp_pred_valid  in  1  predictor BTB hit
bp_pred_taken  in  1  predicted taken
bp_pred_target  in  VADDR_WIDTH  predicted target
fetch_valid  out  1  fetch request valid
fetch_ready  in  1  I-cache accepts request
fetch_pc  out  VADDR_WIDTH  request PC
fetch_pred_taken  out  1  prediction carried with request
fetch_pred_target  out  VADDR_WIDTH  predicted target carried with request
fetch_epoch  out  EPOCH_WIDTH  epoch of request
flush  out  1  one-cycle pulse to downstream queue on redirect

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge. While rst is high:
  - pc_q=RESET_VECTOR, state=BOOT, epoch_q=0.
  - fetch_valid=0, bp_predict_valid=0, flush=0.
- FSM states: BOOT, RUN.
  - BOOT: fetch_valid=0; next state is RUN unconditionally.
  - RUN: normal operation. There is no other state; fetch_halt and redirect are handled inside RUN.
- Combinational outputs:
  - bp_pc = pc_q always.
  - fetch_pc = pc_q.
  - fetch_valid = (state==RUN) && !redirect_valid && !fetch_halt.
  - fire = fetch_valid && fetch_ready.
  - bp_predict_valid = fire. The predictor must only see committed lookups, otherwise its RAS double-pushes during stalls.
  - taken_pred = bp_pred_valid && bp_pred_taken.
  - fetch_pred_taken = taken_pred.
  - fetch_pred_target = bp_pred_target when taken_pred, else 0.
  - fetch_epoch = epoch_q.
- Predictor read is combinational, so the prediction lands in the same cycle as pc_q (zero-bubble for predicted-taken).
- Next-state update, priority high to low:
  1. redirect_valid (any state, including BOOT and during fetch_halt):
     - pc_q <= {redirect_pc[VADDR_WIDTH-1:2],2'b00}
     - epoch_q <= epoch_q+1, wrapping mod 2^EPOCH_WIDTH
     - state <= RUN
     - flush=1 in that same cycle (combinational)
     - no fetch fires in the redirect cycle.
  2. fire && taken_pred: pc_q <= {bp_pred_target[VADDR_WIDTH-1:2],2'b00}.
  3. fire: pc_q <= pc_q+4, wrapping mod 2^VADDR_WIDTH.
  4. Otherwise (stall, halt, BOOT): pc_q holds.
- Stall: while fetch_valid && !fetch_ready, the outputs pc/pred/epoch must stay stable cycle to cycle. The predictor is stateless for reads, so the outputs are stable as long as the predictor is not updated. bp_predict_valid=0.
- Back-to-back redirects: each one increments the epoch, and the last one wins. The first fetch happens the cycle after the final redirect.
- Reset mid-stall or mid-redirect: reset wins and all state returns to its reset values.

Test Plan:
- Reset release: rst high for 3 cycles, then low.
  - Cycle 1 after release: fetch_valid=0 (BOOT).
  - Cycle 2: fetch_valid=1, fetch_pc=0x80000000, epoch=0.
- Sequential: fetch_ready=1, no BTB hits, 4 cycles -> fetch_pc=0x80000000, 0x80000004, 0x80000008, 0x8000000C; bp_predict_valid=1 each cycle.
- Predicted taken: at pc 0x80000008, bp_pred_valid=1, bp_pred_taken=1, target=0x80001000 -> fetch_pred_taken=1, and the next fetch_pc is 0x80001000 with no bubble.
- Stall: fetch_ready=0 for 5 cycles at 0x80000010 with a predicted hit.
  - Required: fetch_pc held, bp_predict_valid=0 all 5 cycles.
  - On ready=1: exactly one bp_predict_valid pulse.
- Redirect priority: redirect_valid=1, redirect_pc=0x80002003, with fetch_ready=1 and taken_pred=1 in the same cycle.
  - Same cycle: fetch_valid=0, flush=1.
  - Next cycle: fetch_pc=0x80002000, epoch=1.
  - 8 more redirects -> epoch wraps to 1 (9 mod 8).
- Wrap and halt: pc_q=0x7FFFFFFFFC, fire -> pc_q=0x0. Then fetch_halt=1 with redirect_valid=1 -> pc loads the redirect target while fetch_valid stays 0.
